fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer between the program counter and the decode stage. It reads the current PC, issues a request/acknowledge read to instruction memory, and presents the returned instruction downstream with a valid/ready handshake. It drives the PC's write-enable and next-address inputs: sequential increment on each completed fetch, or a redirect target from execute. In-flight fetches are discarded on redirect.

## Interface

- `ADDR_W`, 5, PC / instruction-memory address width
- `INSTR_W`, 8, instruction word width

- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable; a new fetch starts only while high
- `pc_addr`  in  ADDR_W  current PC value (PC register output)
- `pc_we`  out  1  PC write enable (combinational)
- `pc_in`  out  ADDR_W  PC next value (combinational)
- `imem_req`  out  1  memory read request (registered)
- `imem_addr`  out  ADDR_W  memory read address (registered)
- `imem_ack`  in  1  memory read complete; `imem_data` valid this cycle
- `imem_data`  in  INSTR_W  returned instruction
- `instr`  out  INSTR_W  instruction to decode (registered)
- `instr_pc`  out  ADDR_W  address `instr` was fetched from (registered)
- `instr_valid`  out  1  `instr` valid (registered)
- `instr_ready`  in  1  decode accepts `instr`
- `redirect`  in  1  one-cycle pulse: change flow to `redirect_addr`
- `redirect_addr`  in  ADDR_W  redirect target

## Operation

- States: IDLE, FETCH, DRAIN, HOLD. Reset (`rst` low, async): state IDLE. `imem_req`, `imem_addr`, `instr`, `instr_pc` and `instr_valid` are all 0.
- IDLE: if `en` and not `redirect`, latch `pc_addr` into `imem_addr`, set `imem_req`, and go to FETCH.
- FETCH: `imem_req` is held high and `imem_addr` is held stable until `imem_ack`.
  - On `imem_ack` without `redirect`: pulse `pc_we` with `pc_in = imem_addr + 1` (mod 2^ADDR_W; 31 wraps to 0). Latch `imem_data` into `instr` and `imem_addr` into `instr_pc`. Set `instr_valid`, clear `imem_req`, and go to HOLD.
- HOLD: `instr_valid`, `instr` and `instr_pc` stay stable until `instr_valid && instr_ready`. On that handshake:
  - if `en`, start the next fetch from `pc_addr` (FETCH, same rules as in IDLE);
  - otherwise clear `instr_valid` and go to IDLE.
- Redirect, in any state: `pc_we = 1` and `pc_in = redirect_addr` that cycle. Redirect beats the increment in every case.
  - In IDLE or HOLD: `instr_valid` is cleared (the held instruction is dropped even if `instr_ready` is high the same cycle) and the state goes to IDLE.
  - In FETCH with `imem_ack` the same cycle: `imem_data` is discarded, `imem_req` is cleared, and the state goes to IDLE.
  - In FETCH without `imem_ack`: `imem_req` and `imem_addr` are held, and the state goes to DRAIN.
- DRAIN: `imem_req` is held until `imem_ack`. The returned data is discarded, `pc_we` is not asserted, and the state goes to IDLE. A further `redirect` in DRAIN rewrites the PC again and stays in DRAIN.
- `pc_we` is low in every case not listed above.
- `en` low does not abort an outstanding request; it only blocks new ones.

## Timing

- Request rule: once `imem_req` is asserted it stays high, with `imem_addr` stable, until the cycle `imem_ack` is sampled high. `imem_ack` may arrive in the first request cycle.
- Latency:
  - IDLE with `en`: `imem_req` is high 1 cycle later.
  - `imem_ack` cycle: `instr_valid` is high 1 cycle later, and `pc_addr` shows the incremented value 1 cycle later.
- Throughput: with zero-wait memory and `instr_ready` held high, one instruction every 2 cycles (FETCH, HOLD).
- Redirect takes effect at the next edge. The first fetch from the new target issues `imem_req` 2 cycles after the redirect (DRAIN adds the remaining memory wait).
- `rst` asserted mid-fetch: all state clears immediately. Memory must tolerate an abandoned request.

## Test plan

- Reset and start: hold `rst` low with `pc_addr = 0`, then release with `en = 1` and zero-wait memory returning 8'hA3 -> `imem_addr = 0` and `imem_req` high on cycle 1. `pc_we` pulses with `pc_in = 1`. `instr = 8'hA3`, `instr_pc = 0`, `instr_valid` high on cycle 2.
- Wait states and backpressure: `imem_ack` delayed 3 cycles, then `instr_ready` low for 4 cycles -> `imem_req` and `imem_addr` stable throughout the wait. `instr` is unchanged while `instr_ready` is low. Exactly one `pc_we` pulse.
- Wrap-around: fetch at `pc_addr = 31` -> `pc_in = 0` on the ack cycle.
- Redirect in HOLD: `instr_valid` high with `instr_ready` high, and `redirect` to 5'd12 in the same cycle -> no transfer (instruction dropped). `pc_in = 12`, and the next fetch is at `imem_addr = 12`.
- Redirect in FETCH with ack 2 cycles later: redirect to 5'd7 -> DRAIN, and the returned data never appears as `instr_valid`. Only one `pc_we` pulse (value 7), then fetch at 7.
- Redirect coincident with `imem_ack`: `pc_in = redirect_addr`, not the increment. Data discarded, state IDLE.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction-fetch sequencer (PC -> instruction memory -> decode)
// Rev 1.0
// ============================================================================
module fetch_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_we,
  output logic [ADDR_W-1:0]  pc_in,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_req;
  logic                 w_req_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    w_addr_nxt;
  logic [INSTR_W-1:0]   r_instr;
  logic [INSTR_W-1:0]   w_instr_nxt;
  logic [ADDR_W-1:0]    r_instr_pc;
  logic [ADDR_W-1:0]    w_instr_pc_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 w_start;
  logic [ADDR_W-1:0]    w_pc_inc;

  assign w_start  = en && !redirect;
  assign w_pc_inc = r_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    pc_we          = 1'b0;
    pc_in          = w_pc_inc;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = pc_addr;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          // A redirected fetch that has not completed must still be drained
          if (imem_ack) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else if (imem_ack) begin
          pc_we          = 1'b1;
          pc_in          = w_pc_inc;
          w_instr_nxt    = imem_data;
          w_instr_pc_nxt = r_addr;
          w_valid_nxt    = 1'b1;
          w_req_nxt      = 1'b0;
          w_state_nxt    = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (instr_ready) begin
          w_valid_nxt = 1'b0;
          if (en) begin
            w_req_nxt   = 1'b1;
            w_addr_nxt  = pc_addr;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Redirect always owns the PC write, overriding any increment
    if (redirect) begin
      pc_we = 1'b1;
      pc_in = redirect_addr;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fetch_ctrl : randomized scoreboard bench for fetch_ctrl
// Rev 1.0
// ============================================================================
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [4:0] pc_addr;
  logic       pc_we;
  logic [4:0] pc_in;
  logic       imem_req;
  logic [4:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic [7:0] instr;
  logic [4:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       redirect = 1'b0;
  logic [4:0] redirect_addr = 5'd0;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(5), .INSTR_W(8)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .pc_addr       (pc_addr),
    .pc_we         (pc_we),
    .pc_in         (pc_in),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
  );

  // PC register owned by the environment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       pc_addr <= 5'd0;
    else if (pc_we) pc_addr <= pc_in;
  end

  typedef struct packed {
    logic [7:0] d;
    logic [4:0] a;
  } xfer_t;

  xfer_t      exp_q[$];
  logic [7:0] mem [32];
  int         n_checks = 0;
  int         n_fail = 0;
  int         force_wait = -1;
  bit         mem_busy = 0;
  int         mem_wait = 0;

  // Transaction-level reference state
  bit         m_req = 0;      // a fetch request is outstanding
  logic [4:0] m_addr = 5'd0;  // address of that request
  bit         m_cancel = 0;   // outstanding request was overtaken by a redirect
  bit         m_held = 0;     // an instruction is waiting for decode
  logic [4:0] m_pc = 5'd0;    // architectural PC

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_req = 0; m_cancel = 0; m_held = 0; m_pc = 5'd0; m_addr = 5'd0;
    mem_busy = 0; mem_wait = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #3;
    rst = 1'b0; en = 1'b0; redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    #1;
    chk(imem_req == 1'b0, "rst_imem_req", imem_req, 0);
    chk(imem_addr == 5'd0, "rst_imem_addr", imem_addr, 0);
    chk(instr == 8'd0, "rst_instr", instr, 0);
    chk(instr_pc == 5'd0, "rst_instr_pc", instr_pc, 0);
    chk(instr_valid == 1'b0, "rst_instr_valid", instr_valid, 0);
    chk(pc_we == 1'b0, "rst_pc_we", pc_we, 0);
    clear_model();
    repeat (cycles) @(negedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic step(input bit e, input bit r, input bit rd, input logic [4:0] ra);
    bit         live;
    bit         start;
    logic [4:0] exp_in;
    xfer_t      ent;
    @(negedge clk);
    en = e; instr_ready = r; redirect = rd; redirect_addr = ra;
    imem_ack = 1'b0;
    imem_data = 8'($urandom);
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
      end
      if (mem_wait == 0) begin
        imem_ack = 1'b1;
        imem_data = mem[imem_addr];
        mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end
    #1;
    chk(imem_req == m_req, "imem_req", imem_req, m_req);
    if (m_req) chk(imem_addr == m_addr, "imem_addr", imem_addr, m_addr);
    chk(instr_valid == m_held, "instr_valid", instr_valid, m_held);
    chk(pc_addr == m_pc, "pc_addr", pc_addr, m_pc);
    live = imem_ack && m_req && !m_cancel;
    exp_in = rd ? ra : 5'(m_addr + 5'd1);
    chk(pc_we == (rd || live), "pc_we", pc_we, rd || live);
    if (rd || live) chk(pc_in == exp_in, "pc_in", pc_in, exp_in);

    start = !m_req && (!m_held || (r && !rd)) && e && !rd;
    if (rd && m_held) void'(exp_q.pop_back());
    if (rd) m_held = 0;
    else if (m_held && r) m_held = 0;
    else if (live) begin
      m_held = 1;
      ent.d = mem[m_addr];
      ent.a = m_addr;
      exp_q.push_back(ent);
    end
    if (m_req && !imem_ack && rd) m_cancel = 1;
    else if (imem_ack) m_cancel = 0;
    m_req = start || (m_req && !imem_ack);
    if (rd) m_pc = ra;
    else if (live) m_pc = 5'(m_addr + 5'd1);
    if (start) m_addr = pc_addr;
  endtask

  task automatic wait_held();
    int k;
    for (k = 0; k < 20 && !m_held; k++) step(1, 0, 0, 5'd0);
    chk(m_held, "wait_held_budget", k, 20);
  endtask

  // Output monitor: pops the scoreboard on every accepted transfer
  bit         prev_hold = 0;
  logic [7:0] prev_instr = 8'd0;
  logic [4:0] prev_pc = 5'd0;
  always @(negedge clk) begin
    xfer_t got;
    #2;
    if (rst) begin
      if (instr_valid && prev_hold) begin
        chk(instr == prev_instr, "instr_stable", instr, prev_instr);
        chk(instr_pc == prev_pc, "instr_pc_stable", instr_pc, prev_pc);
      end
      if (instr_valid && instr_ready && !redirect) begin
        chk(exp_q.size() != 0, "xfer_expected", 1, exp_q.size());
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk(instr == got.d, "xfer_instr", instr, got.d);
          chk(instr_pc == got.a, "xfer_instr_pc", instr_pc, got.a);
        end
        prev_hold = 0;
      end else begin
        prev_hold = instr_valid && !redirect;
      end
      prev_instr = instr;
      prev_pc = instr_pc;
    end else begin
      prev_hold = 0;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA3;

    // Reset, then start with zero-wait memory
    do_reset(3);
    force_wait = 0;
    repeat (4) step(1, 1, 0, 5'd0);

    // Wait states with decode backpressure
    force_wait = 3;
    repeat (12) step(1, 0, 0, 5'd0);
    repeat (3) step(0, 1, 0, 5'd0);

    // Wrap-around from address 31
    force_wait = 0;
    repeat (4) step(0, 1, 0, 5'd0);
    step(0, 1, 1, 5'd31);
    repeat (4) step(1, 1, 0, 5'd0);

    // Redirect while holding, with decode ready the same cycle
    wait_held();
    step(1, 1, 1, 5'd12);
    repeat (4) step(1, 1, 0, 5'd0);

    // Redirect in the first cycle of a two-wait fetch
    repeat (6) step(0, 1, 0, 5'd0);
    force_wait = 2;
    step(1, 1, 0, 5'd0);
    step(1, 1, 1, 5'd7);
    repeat (8) step(1, 1, 0, 5'd0);

    // Redirect coincident with the ack
    repeat (6) step(0, 1, 0, 5'd0);
    force_wait = 0;
    step(1, 1, 0, 5'd0);
    step(1, 1, 1, 5'd9);
    repeat (4) step(1, 1, 0, 5'd0);

    // Randomized traffic with a reset in the middle
    force_wait = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 8, 5'($urandom));
    end

    force_wait = 0;
    repeat (10) step(0, 1, 0, 5'd0);
    #3;
    chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
